// File: rtl/store_buf_pkg.sv
// Shared constants, helpers and the default-width entry layout for the bus store buffer.
package store_buf_pkg;

   localparam int WORD_LSB   = 2;
   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   // Pointer width carries one wrap bit above the index so full and empty differ.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef struct packed {
      logic [DEF_ADDR_W-1:0]   addr;
      logic [DEF_DATA_W-1:0]   data;
      logic [DEF_DATA_W/8-1:0] strb;
   } store_entry_t;

endpackage

// File: rtl/store_buf_match.sv
// DEPTH-way word-address comparator; one hit bit per entry, gated by that entry's valid bit.
module store_buf_match
   import store_buf_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic [DEPTH-1:0][ADDR_W-WORD_LSB-1:0] words,
   input  logic [DEPTH-1:0]                      valid,
   input  logic [ADDR_W-WORD_LSB-1:0]            key,
   output logic [DEPTH-1:0]                      hit
);

   always_comb begin
      hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit[i] = valid[i] && (words[i] == key);
      end
   end

endmodule

// File: rtl/bus_store_buffer.sv
// DEPTH-entry byte-strobed store FIFO between the store/load stage and the write bus, with load probe.
// Optional tail coalescing of same-word stores is enabled by defining STORE_BUF_COALESCE_EN.
module bus_store_buffer
   import store_buf_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int ADDR_W = 32,
   parameter  int DEPTH  = 4,
   localparam int STRB_W = DATA_W / 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_W-1:0]          in_addr,
   input  logic [DATA_W-1:0]          in_data,
   input  logic [STRB_W-1:0]          in_strb,
   output logic                       bus_write_valid,
   input  logic                       bus_write_ready,
   output logic [ADDR_W-1:0]          bus_addr,
   output logic [DATA_W-1:0]          bus_dout,
   output logic [STRB_W-1:0]          bus_strb,
   input  logic [ADDR_W-1:0]          probe_addr,
   output logic                       probe_hit,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       idle
);

   localparam int PTR_W  = ptr_w(DEPTH);
   localparam int IDX_W  = PTR_W - 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int WORD_W = ADDR_W - WORD_LSB;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
   } buf_entry_t;

   buf_entry_t                    mem [DEPTH];
   logic [PTR_W-1:0]              rd_ptr, wr_ptr;
   logic [DEPTH-1:0]              vld, vld_next;
   logic [CNT_W-1:0]              cnt;
   logic [IDX_W-1:0]              rd_idx, wr_idx;
   logic                          full, empty, pop, push_alloc;
   logic [DEPTH-1:0][WORD_W-1:0]  words;
   logic [DEPTH-1:0]              probe_vec;
   logic                          probe_lsb_unused;

   assign rd_idx = rd_ptr[IDX_W-1:0];
   assign wr_idx = wr_ptr[IDX_W-1:0];
   assign full   = (rd_idx == wr_idx) && (rd_ptr[PTR_W-1] != wr_ptr[PTR_W-1]);
   assign empty  = (rd_ptr == wr_ptr);

   assign bus_write_valid = !empty;
   assign pop             = bus_write_valid && bus_write_ready;
   assign bus_addr        = mem[rd_idx].addr;
   assign bus_dout        = mem[rd_idx].data;
   assign bus_strb        = mem[rd_idx].strb;
   assign count           = cnt;
   assign idle            = (cnt == '0);

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         words[i] = mem[i].addr[ADDR_W-1:WORD_LSB];
      end
   end

   // Only registered entries are matched, so a same-cycle push never raises probe_hit.
   store_buf_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_probe_match (
      .words (words),
      .valid (vld),
      .key   (probe_addr[ADDR_W-1:WORD_LSB]),
      .hit   (probe_vec)
   );

   assign probe_hit        = |probe_vec;
   assign probe_lsb_unused = ^probe_addr[WORD_LSB-1:0];

`ifdef STORE_BUF_COALESCE_EN
   logic [IDX_W-1:0]  tail_idx;
   logic [DEPTH-1:0]  tail_mask, tail_vec;
   logic              merge_ok, merge;
   logic [DATA_W-1:0] merge_data;
   logic [STRB_W-1:0] merge_strb;

   assign tail_idx  = wr_idx - 1'b1;
   assign tail_mask = {{(DEPTH-1){1'b0}}, 1'b1} << tail_idx;

   store_buf_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_tail_match (
      .words (words),
      .valid (vld & tail_mask),
      .key   (in_addr[ADDR_W-1:WORD_LSB]),
      .hit   (tail_vec)
   );

   // Merging is limited to a tail that is not the head, so the bus never sees an entry change under it.
   assign merge_ok   = (cnt >= CNT_W'(2)) && (|tail_vec) && (tail_idx != rd_idx)
                       && !(pop && (tail_idx == rd_idx));
   assign in_ready   = !full || merge_ok;
   assign merge      = in_valid && merge_ok;
   assign push_alloc = in_valid && !full && !merge_ok;

   always_comb begin
      merge_data = mem[tail_idx].data;
      for (int b = 0; b < STRB_W; b++) begin
         if (in_strb[b]) merge_data[8*b +: 8] = in_data[8*b +: 8];
      end
      merge_strb = mem[tail_idx].strb | in_strb;
   end

   always_ff @(posedge clk) begin
      if (push_alloc) begin
         mem[wr_idx] <= '{addr: in_addr, data: in_data, strb: in_strb};
      end else if (merge) begin
         mem[tail_idx] <= '{addr: mem[tail_idx].addr, data: merge_data, strb: merge_strb};
      end
   end
`else
   assign in_ready   = !full;
   assign push_alloc = in_valid && !full;

   always_ff @(posedge clk) begin
      if (push_alloc) begin
         mem[wr_idx] <= '{addr: in_addr, data: in_data, strb: in_strb};
      end
   end
`endif

   always_comb begin
      vld_next = vld;
      if (push_alloc) vld_next[wr_idx] = 1'b1;
      if (pop)        vld_next[rd_idx] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         vld    <= '0;
         cnt    <= '0;
      end else begin
         vld <= vld_next;
         if (push_alloc) wr_ptr <= wr_ptr + 1'b1;
         if (pop)        rd_ptr <= rd_ptr + 1'b1;
         case ({push_alloc, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_store_buffer.sv
// Scoreboard bench for bus_store_buffer: directed stores, a monitor checks every bus write in order.
module tb_bus_store_buffer;
   import store_buf_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic [3:0]  in_strb;
   logic        bus_write_valid;
   logic        bus_write_ready;
   logic [31:0] bus_addr;
   logic [31:0] bus_dout;
   logic [3:0]  bus_strb;
   logic [31:0] probe_addr;
   logic        probe_hit;
   logic [2:0]  count;
   logic        idle;

   int n_cmp = 0;
   int n_err = 0;
   store_entry_t exp_q[$];

   bus_store_buffer dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_addr         (in_addr),
      .in_data         (in_data),
      .in_strb         (in_strb),
      .bus_write_valid (bus_write_valid),
      .bus_write_ready (bus_write_ready),
      .bus_addr        (bus_addr),
      .bus_dout        (bus_dout),
      .bus_strb        (bus_strb),
      .probe_addr      (probe_addr),
      .probe_hit       (probe_hit),
      .count           (count),
      .idle            (idle)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted bus write is compared with the oldest expected store.
   always @(negedge clk) begin
      if (rst_n && bus_write_valid && bus_write_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_unexpected: got addr 0x%0h, expected no write", bus_addr);
         end else begin
            store_entry_t e;
            e = exp_q.pop_front();
            chk("drain_addr", 64'(bus_addr), 64'(e.addr));
            chk("drain_data", 64'(bus_dout), 64'(e.data));
            chk("drain_strb", 64'(bus_strb), 64'(e.strb));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input bit track);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      in_strb  = s;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk("push_timeout", 64'(in_ready), 64'd1);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end else begin
         if (track) exp_q.push_back('{addr: a, data: d, strb: s});
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (idle && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      chk(name, 64'(ok), 64'd1);
   endtask

   initial begin
      rst_n           = 1'b0;
      in_valid        = 1'b0;
      in_addr         = '0;
      in_data         = '0;
      in_strb         = '0;
      bus_write_ready = 1'b0;
      probe_addr      = '0;
      step();
      step();
      rst_n = 1'b1;
      step();

      chk("rst_count", 64'(count), 64'd0);
      chk("rst_idle", 64'(idle), 64'd1);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_bus_valid", 64'(bus_write_valid), 64'd0);
      chk("rst_probe_hit", 64'(probe_hit), 64'd0);

      // Basic push and drain
      bus_write_ready = 1'b1;
      push(32'hE000_0000, 32'h1122_3344, 4'hF, 1'b1);
      chk("t1_valid_next_cycle", 64'(bus_write_valid), 64'd1);
      chk("t1_count_one", 64'(count), 64'd1);
      step();
      chk("t1_count_zero", 64'(count), 64'd0);
      chk("t1_idle", 64'(idle), 64'd1);

      // Backpressure fill, then a pop while full
      bus_write_ready = 1'b0;
      push(32'hE000_0100, 32'hA0A0_0001, 4'hF, 1'b1);
      push(32'hE000_0104, 32'hA0A0_0002, 4'h3, 1'b1);
      push(32'hE000_0108, 32'hA0A0_0003, 4'hC, 1'b1);
      push(32'hE000_010C, 32'hA0A0_0004, 4'h1, 1'b1);
      chk("t2_count_full", 64'(count), 64'd4);
      chk("t2_in_ready_low", 64'(in_ready), 64'd0);
      chk("t2_head_stable", 64'(bus_addr), 64'hE000_0100);
      in_valid = 1'b1;
      in_addr  = 32'hE000_0110;
      in_data  = 32'hA0A0_0005;
      in_strb  = 4'h8;
      exp_q.push_back('{addr: 32'hE000_0110, data: 32'hA0A0_0005, strb: 4'h8});
      step();
      chk("t2_held_count", 64'(count), 64'd4);
      chk("t2_held_head", 64'(bus_dout), 64'hA0A0_0001);
      bus_write_ready = 1'b1;
      step();
      chk("t3_pop_no_push", 64'(count), 64'd3);
      chk("t3_ready_again", 64'(in_ready), 64'd1);
      step();
      chk("t3_push_and_pop", 64'(count), 64'd3);
      in_valid = 1'b0;
      wait_idle("t2_drain_done");

      // Probe
      bus_write_ready = 1'b0;
      push(32'hE000_0010, 32'h5555_6666, 4'hF, 1'b1);
      probe_addr = 32'hE000_0012;
      #1;
      chk("t4_probe_same_word", 64'(probe_hit), 64'd1);
      probe_addr = 32'hE000_0014;
      #1;
      chk("t4_probe_next_word", 64'(probe_hit), 64'd0);
      probe_addr      = 32'hE000_0012;
      bus_write_ready = 1'b1;
      #1;
      chk("t4_probe_while_popping", 64'(probe_hit), 64'd1);
      step();
      chk("t4_probe_after_drain", 64'(probe_hit), 64'd0);

      // Reset mid-operation
      bus_write_ready = 1'b0;
      push(32'hE000_0200, 32'h0000_0001, 4'hF, 1'b1);
      push(32'hE000_0204, 32'h0000_0002, 4'hF, 1'b1);
      push(32'hE000_0208, 32'h0000_0003, 4'hF, 1'b1);
      chk("t5_count_three", 64'(count), 64'd3);
      probe_addr = 32'hE000_0204;
      rst_n = 1'b0;
      exp_q.delete();
      step();
      rst_n = 1'b1;
      chk("t5_count", 64'(count), 64'd0);
      chk("t5_bus_valid", 64'(bus_write_valid), 64'd0);
      chk("t5_idle", 64'(idle), 64'd1);
      chk("t5_probe_cleared", 64'(probe_hit), 64'd0);

      // Same-word stores into the tail
      push(32'hE000_0020, 32'h0000_00AA, 4'h1, 1'b0);
      push(32'hE000_0030, 32'h0000_0011, 4'h1, 1'b0);
      push(32'hE000_0030, 32'h0000_BB00, 4'h2, 1'b0);
      exp_q.push_back('{addr: 32'hE000_0020, data: 32'h0000_00AA, strb: 4'h1});
`ifdef STORE_BUF_COALESCE_EN
      chk("t6_count_merged", 64'(count), 64'd2);
      exp_q.push_back('{addr: 32'hE000_0030, data: 32'h0000_BB11, strb: 4'h3});
`else
      chk("t6_count_separate", 64'(count), 64'd3);
      exp_q.push_back('{addr: 32'hE000_0030, data: 32'h0000_0011, strb: 4'h1});
      exp_q.push_back('{addr: 32'hE000_0030, data: 32'h0000_BB00, strb: 4'h2});
`endif
      bus_write_ready = 1'b1;
      wait_idle("t6_drain_done");

      step();
      chk("end_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
